// File: rtl/aes_pkg.sv
// Shared AES constants: byte type, table geometry and the forward S-box (SubBytes) table.
// Combinational constants only; no latency and no flow control.
// The table doubles as the power-up image of the dual-port S-box memory.
package aes_pkg;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;
    localparam int SBOX_DEPTH = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] byte_t;

    localparam byte_t AES_SBOX [SBOX_DEPTH] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic byte_t sbox_f(input byte_t b);
        return AES_SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sbox_port.sv
// One access port of the S-box RAM: write request out, read-first registered data back.
// Latency 1 edge (2 with AES_SBOX_OUTREG_EN); every stage advances only while en is high.
// No backpressure: en is the only stall, and a stalled port holds its output.
module aes_sbox_port
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [7:0]  di,
    input  logic [7:0]  mem_rdat,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdat,
    output logic [7:0]  dout
);

    byte_t rd_q;

    assign mem_we   = en & we;
    assign mem_addr = addr;
    assign mem_wdat = di;

    // mem_rdat is sampled on the same edge that commits a write, so the old word is returned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else if (en) begin
            rd_q <= mem_rdat;
        end
    end

`ifdef AES_SBOX_OUTREG_EN
    byte_t out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else if (en) begin
            out_q <= rd_q;
        end
    end

    assign dout = out_q;
`else
    assign dout = rd_q;
`endif

endmodule

// File: rtl/aes_128_sbox_dp.sv
// Dual-port 256x8 RAM preloaded with the AES forward S-box; two lookups per clock.
// Latency 1 edge (2 with AES_SBOX_OUTREG_EN); same-address writes resolve to port A.
// No backpressure: ports stall only via ena/enb; rst clears outputs, never the table.
module aes_128_sbox_dp
    import aes_pkg::*;
#(
    parameter int ADDR_W = aes_pkg::ADDR_W,
    parameter int DATA_W = aes_pkg::DATA_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        enb,
    input  logic        wea,
    input  logic        web,
    input  logic [7:0]  addra,
    input  logic [7:0]  addrb,
    input  logic [7:0]  dia,
    input  logic [7:0]  dib,
    output logic [7:0]  doa,
    output logic [7:0]  dob
);

    if (ADDR_W != 8 || DATA_W != 8) begin : g_bad_geometry
        $error("aes_128_sbox_dp: ADDR_W and DATA_W are fixed at 8");
    end

    // Power-up image only; rst deliberately leaves the table alone
    byte_t mem [SBOX_DEPTH] = AES_SBOX;

    logic  a_we, b_we;
    byte_t a_addr, b_addr;
    byte_t a_wdat, b_wdat;
    byte_t a_rdat, b_rdat;

    assign a_rdat = mem[a_addr];
    assign b_rdat = mem[b_addr];

    // Port A is written last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (b_we) begin
            mem[b_addr] <= b_wdat;
        end
        if (a_we) begin
            mem[a_addr] <= a_wdat;
        end
    end

    aes_sbox_port u_port_a (
        .clk      (clk),
        .rst      (rst),
        .en       (ena),
        .we       (wea),
        .addr     (addra),
        .di       (dia),
        .mem_rdat (a_rdat),
        .mem_we   (a_we),
        .mem_addr (a_addr),
        .mem_wdat (a_wdat),
        .dout     (doa)
    );

    aes_sbox_port u_port_b (
        .clk      (clk),
        .rst      (rst),
        .en       (enb),
        .we       (web),
        .addr     (addrb),
        .di       (dib),
        .mem_rdat (b_rdat),
        .mem_we   (b_we),
        .mem_addr (b_addr),
        .mem_wdat (b_wdat),
        .dout     (dob)
    );

endmodule

// File: tb/tb_aes_128_sbox_dp.sv
// Bench for aes_128_sbox_dp: S-box derived from GF(2^8) inversion plus the affine map,
// a behavioural RAM model, constant spot vectors, corner sequences and random traffic.
module tb_aes_128_sbox_dp;

`ifdef AES_SBOX_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ena, enb, wea, web;
    logic [7:0] addra, addrb, dia, dib;
    logic [7:0] doa, dob;

    int tests = 0;
    int fails = 0;

    logic [7:0] ref_mem [256];
    logic [7:0] exp_a, exp_b, s1_a, s1_b;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ea;
        logic [7:0] eb;
    } vec_t;
    vec_t vecs [6];

    aes_128_sbox_dp dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .enb   (enb),
        .wea   (wea),
        .web   (web),
        .addra (addra),
        .addrb (addrb),
        .dia   (dia),
        .dib   (dib),
        .doa   (doa),
        .dob   (dob)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p = 8'h00;
        logic [7:0] a = x;
        logic [7:0] b = y;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    // Behavioural effect of one rising edge with the inputs currently applied
    task automatic model_edge();
        logic [7:0] ra, rb;
        ra = ref_mem[addra];
        rb = ref_mem[addrb];
        if (enb && web) ref_mem[addrb] = dib;
        if (ena && wea) ref_mem[addra] = dia;
        if (ena) begin
            if (LAT == 2) begin exp_a = s1_a; s1_a = ra; end
            else exp_a = ra;
        end
        if (enb) begin
            if (LAT == 2) begin exp_b = s1_b; s1_b = rb; end
            else exp_b = rb;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic chk_model(input string nm);
        chk({nm, "_a"}, doa, exp_a);
        chk({nm, "_b"}, dob, exp_b);
    endtask

    task automatic drive(input logic a_en, input logic a_we, input logic [7:0] a_ad, input logic [7:0] a_di,
                         input logic b_en, input logic b_we, input logic [7:0] b_ad, input logic [7:0] b_di);
        ena = a_en; wea = a_we; addra = a_ad; dia = a_di;
        enb = b_en; web = b_we; addrb = b_ad; dib = b_di;
    endtask

    task automatic read_both(input logic [7:0] a, input logic [7:0] b);
        drive(1'b1, 1'b0, a, 8'h00, 1'b1, 1'b0, b, 8'h00);
        repeat (LAT) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{a: 8'h00, b: 8'hff, ea: 8'h63, eb: 8'h16};
        vecs[1] = '{a: 8'h01, b: 8'h10, ea: 8'h7c, eb: 8'hca};
        vecs[2] = '{a: 8'h53, b: 8'h80, ea: 8'hed, eb: 8'hcd};
        vecs[3] = '{a: 8'h80, b: 8'h53, ea: 8'hcd, eb: 8'hed};
        vecs[4] = '{a: 8'h53, b: 8'h53, ea: 8'hed, eb: 8'hed};
        vecs[5] = '{a: 8'hff, b: 8'h00, ea: 8'h16, eb: 8'h63};

        for (int i = 0; i < 256; i++) ref_mem[i] = sbox_ref(8'(i));
        exp_a = 8'h00; exp_b = 8'h00; s1_a = 8'h00; s1_b = 8'h00;

        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        #2;
        chk("reset_doa", doa, 8'h00);
        chk("reset_dob", dob, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Constant spot vectors; the first read after reset release must already be valid
        for (int i = 0; i < 6; i++) begin
            read_both(vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d_a", i), doa, vecs[i].ea);
            chk($sformatf("vec%0d_b", i), dob, vecs[i].eb);
        end

        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b0, 8'(i), 8'h00, 1'b1, 1'b0, 8'(i), 8'h00);
            tick();
            chk_model($sformatf("sweep%02h", i));
        end

        // Enable hold
        read_both(8'h53, 8'h53);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) tick();
        chk("hold_doa", doa, 8'hed);
        chk("hold_dob", dob, 8'hed);

        // Write is read-first; the new word appears on the next read
        read_both(8'h00, 8'h00);
        drive(1'b1, 1'b1, 8'h01, 8'haa, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
`ifndef AES_SBOX_OUTREG_EN
        chk("write_old_doa", doa, 8'h7c);
`endif
        read_both(8'h01, 8'h01);
        chk("write_new_doa", doa, 8'haa);
        chk("write_new_dob", dob, 8'haa);

        // Same-address double write: A wins
        drive(1'b1, 1'b1, 8'h02, 8'h11, 1'b1, 1'b1, 8'h02, 8'h22);
        tick();
        read_both(8'h02, 8'h02);
        chk("collide_doa", doa, 8'h11);
        chk("collide_dob", dob, 8'h11);

        // A writes while B reads the same address: B sees the old word
        drive(1'b1, 1'b1, 8'h03, 8'h55, 1'b1, 1'b0, 8'h03, 8'h00);
        tick();
`ifndef AES_SBOX_OUTREG_EN
        chk("cross_old_dob", dob, 8'h7b);
`endif
        chk_model("cross");
        read_both(8'h03, 8'h03);
        chk("cross_new_dob", dob, 8'h55);

        // Undriven write data is harmless while we is low
        drive(1'b1, 1'b0, 8'h04, 8'hxx, 1'b1, 1'b0, 8'h05, 8'hxx);
        repeat (LAT) tick();
        chk("xdata_doa", doa, 8'hf2);
        chk("xdata_dob", dob, 8'h6b);

        // Mid-run asynchronous reset: outputs clear between edges, table survives
        read_both(8'h00, 8'h00);
        chk("prerst_doa", doa, 8'h63);
        #2 rst = 1'b1;
        exp_a = 8'h00; exp_b = 8'h00; s1_a = 8'h00; s1_b = 8'h00;
        #1;
        chk("midrst_doa", doa, 8'h00);
        chk("midrst_dob", dob, 8'h00);
        #1 rst = 1'b0;
        read_both(8'h01, 8'h53);
        chk("postrst_doa", doa, 8'haa);
        chk("postrst_dob", dob, 8'hed);

`ifdef AES_SBOX_OUTREG_EN
        read_both(8'h00, 8'h00);
        drive(1'b1, 1'b0, 8'h53, 8'h00, 1'b1, 1'b0, 8'h53, 8'h00);
        tick();
        chk("outreg_edge1_doa", doa, 8'h63);
        tick();
        chk("outreg_edge2_doa", doa, 8'hed);
`endif

        // Random traffic against the model, with frequent address collisions
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom_range(0, 255));
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), ra, 8'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), rb, 8'($urandom));
            tick();
            chk_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
